// File: rtl/reg_file.sv
// Architectural integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, optional write-first bypass.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] RS1addr_i,
    input  logic [ADDR_WIDTH-1:0] RS2addr_i,
    input  logic [ADDR_WIDTH-1:0] RDaddr_i,
    input  logic [DATA_WIDTH-1:0] RDdata_i,
    input  logic                  RegWrite_i,
    output logic [DATA_WIDTH-1:0] RS1data_o,
    output logic [DATA_WIDTH-1:0] RS2data_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_wr_en;
    logic                  w_fwd1;
    logic                  w_fwd2;

    // Qualified write: reset wins, and x0 is never a legal destination.
    assign w_wr_en = !rst_i && RegWrite_i && (RDaddr_i != '0);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_entry
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_regs[gi] <= '0;
                    end else if (w_wr_en && (RDaddr_i == ADDR_WIDTH'(gi))) begin
                        r_regs[gi] <= RDdata_i;
                    end
                end
                assign w_regs[gi] = r_regs[gi];
            end
        end
    endgenerate

    // w_wr_en already excludes x0 and reset, so forwarding never targets x0.
    assign w_fwd1 = (BYPASS != 0) && w_wr_en && (RDaddr_i == RS1addr_i);
    assign w_fwd2 = (BYPASS != 0) && w_wr_en && (RDaddr_i == RS2addr_i);

    always_comb begin
        RS1data_o = w_regs[RS1addr_i];
        if (RS1addr_i == '0) begin
            RS1data_o = '0;
        end else if (w_fwd1) begin
            RS1data_o = RDdata_i;
        end
    end

    always_comb begin
        RS2data_o = w_regs[RS2addr_i];
        if (RS2addr_i == '0) begin
            RS2data_o = '0;
        end else if (w_fwd2) begin
            RS2data_o = RDdata_i;
        end
    end

endmodule
